// File: rtl/cdb_issue_scheduler.sv
// cdb_issue_scheduler: grants issue to int/ls/mult/div queues so each result gets a private CDB slot.
module cdb_issue_scheduler #(
  parameter int INT_LAT    = 1,
  parameter int LS_LAT     = 2,
  parameter int MULT_LAT   = 4,
  parameter int DIV_LAT    = 8,
  parameter int STARVE_MAX = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       int_ready,
  input  logic       ls_ready,
  input  logic       mult_ready,
  input  logic       div_ready,
  output logic       int_issue,
  output logic       ls_issue,
  output logic       mult_issue,
  output logic       div_issue,
  output logic [3:0] cdb_sel,
  output logic       cdb_sel_valid,
  output logic       div_busy,
  output logic       starve_active
);
  localparam int SW = $clog2(STARVE_MAX + 1);
  localparam logic [SW-1:0] SMAX = SW'(STARVE_MAX);
  typedef struct packed {
    logic       v;
    logic [1:0] id;
  } slot_t;
  slot_t [DIV_LAT:0] owner_q, owner_d;
  logic [3:0] div_cnt_q, div_cnt_d;
  logic [SW-1:0] int_wait_q, int_wait_d, ls_wait_q, ls_wait_d;
  logic int_starve, ls_starve;
  assign int_starve = int_wait_q >= SMAX;
  assign ls_starve = ls_wait_q >= SMAX;
  assign starve_active = int_starve | ls_starve;
  assign div_busy = div_cnt_q != 4'd0;
  assign int_issue = int_ready & ~owner_q[INT_LAT].v & ~rst;
  assign ls_issue = ls_ready & ~owner_q[LS_LAT].v & ~int_starve & ~rst;
  assign mult_issue = mult_ready & ~owner_q[MULT_LAT].v & ~starve_active & ~rst;
  assign div_issue = div_ready & ~owner_q[DIV_LAT].v & ~starve_active & ~div_busy & ~rst;
  // The CDB select is a pure register decode, so ready inputs never reach it combinationally.
  assign cdb_sel = owner_q[0].v ? 4'b0001 << owner_q[0].id : 4'b0000;
  assign cdb_sel_valid = owner_q[0].v;
  always_comb begin
    owner_d = {3'b000, owner_q[DIV_LAT:1]};
    if (int_issue) owner_d[INT_LAT-1] = '{1'b1, 2'd0};
    if (ls_issue) owner_d[LS_LAT-1] = '{1'b1, 2'd1};
    if (mult_issue) owner_d[MULT_LAT-1] = '{1'b1, 2'd2};
    if (div_issue) owner_d[DIV_LAT-1] = '{1'b1, 2'd3};
    div_cnt_d = div_issue ? 4'(DIV_LAT - 1) : div_busy ? div_cnt_q - 4'd1 : div_cnt_q;
    int_wait_d = (int_ready & ~int_issue) ? (int_starve ? int_wait_q : int_wait_q + 1'b1) : '0;
    ls_wait_d = (ls_ready & ~ls_issue) ? (ls_starve ? ls_wait_q : ls_wait_q + 1'b1) : '0;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      owner_q <= '0;
      div_cnt_q <= '0;
      int_wait_q <= '0;
      ls_wait_q <= '0;
    end else begin
      owner_q <= owner_d;
      div_cnt_q <= div_cnt_d;
      int_wait_q <= int_wait_d;
      ls_wait_q <= ls_wait_d;
    end
  end
endmodule

// File: tb/tb_cdb_issue_scheduler.sv
// tb_cdb_issue_scheduler: directed test-plan scenarios plus random traffic against a CDB calendar model.
module tb_cdb_issue_scheduler;
  logic clk = 1'b0;
  logic rst, int_ready, ls_ready, mult_ready, div_ready;
  logic int_issue, ls_issue, mult_issue, div_issue, cdb_sel_valid, div_busy, starve_active;
  logic [3:0] cdb_sel;
  int checks = 0;
  int errors = 0;
  logic [10:0] obs, exp_v;
  always #5 clk = ~clk;
  cdb_issue_scheduler dut (
    .clk(clk), .rst(rst),
    .int_ready(int_ready), .ls_ready(ls_ready), .mult_ready(mult_ready), .div_ready(div_ready),
    .int_issue(int_issue), .ls_issue(ls_issue), .mult_issue(mult_issue), .div_issue(div_issue),
    .cdb_sel(cdb_sel), .cdb_sel_valid(cdb_sel_valid), .div_busy(div_busy), .starve_active(starve_active)
  );
  // Model: an absolute-time calendar of who owns the bus in each future cycle.
  localparam int N = 32;
  localparam int LAT[4] = '{1, 2, 4, 8};
  localparam int STARVE = 3;
  int booked[N];
  int div_free = 0;
  int wt[2] = '{0, 0};
  int cyc = 0;
  function automatic logic [10:0] m_expect(input logic [3:0] rdy, input logic r);
    logic [3:0] g, sel;
    logic is, ls, busy;
    is = wt[0] >= STARVE;
    ls = wt[1] >= STARVE;
    busy = cyc < div_free;
    for (int u = 0; u < 4; u++) g[u] = rdy[u] && booked[(cyc + LAT[u]) % N] < 0;
    if (is) g[3:1] = 3'b000;
    if (ls) g[3:2] = 2'b00;
    if (busy) g[3] = 1'b0;
    if (r) g = 4'b0000;
    sel = booked[cyc % N] < 0 ? 4'b0000 : 4'(1 << booked[cyc % N]);
    return {g, sel, |sel, busy, is | ls};
  endfunction
  function automatic void m_commit(input logic [3:0] rdy, input logic r, input logic [3:0] g);
    booked[cyc % N] = -1;
    if (r) begin
      for (int i = 0; i < N; i++) booked[i] = -1;
      div_free = 0;
      wt[0] = 0;
      wt[1] = 0;
    end else begin
      for (int u = 0; u < 4; u++) if (g[u]) booked[(cyc + LAT[u]) % N] = u;
      if (g[3]) div_free = cyc + 8;
      for (int u = 0; u < 2; u++) wt[u] = (rdy[u] && !g[u]) ? (wt[u] < STARVE ? wt[u] + 1 : STARVE) : 0;
    end
    cyc++;
  endfunction
  // Drives one cycle's inputs, samples outputs before the edge, then advances the model.
  task automatic drive(input logic [3:0] rdy, input logic r, output logic [10:0] o, output logic [10:0] e);
    {div_ready, mult_ready, ls_ready, int_ready} = rdy;
    rst = r;
    #1;
    o = {div_issue, mult_issue, ls_issue, int_issue, cdb_sel, cdb_sel_valid, div_busy, starve_active};
    e = m_expect(rdy, r);
    @(posedge clk);
    m_commit(rdy, r, e[10:7]);
    @(negedge clk);
  endtask
  task automatic test_reset;
    drive(4'b1111, 1'b1, obs, exp_v);
    checks++;
    if (obs[10:7] !== 4'b0000) begin errors++; $display("FAIL reset_issue got %b exp 0000", obs[10:7]); end
    drive(4'b1111, 1'b1, obs, exp_v);
    checks++;
    if (obs !== 11'b0) begin errors++; $display("FAIL reset_state got %b exp %b", obs, 11'b0); end
  endtask
  task automatic test_single_int;
    drive(4'b0000, 1'b1, obs, exp_v);
    for (int c = 0; c < 4; c++) begin
      drive(c == 0 ? 4'b0001 : 4'b0000, 1'b0, obs, exp_v);
      checks++;
      if (obs !== exp_v) begin errors++; $display("FAIL single_int_model c=%0d got %b exp %b", c, obs, exp_v); end
      checks++;
      if (obs[10:7] !== (c == 0 ? 4'b0001 : 4'b0000)) begin errors++; $display("FAIL single_int_issue c=%0d got %b", c, obs[10:7]); end
      checks++;
      if (obs[6:3] !== (c == 1 ? 4'b0001 : 4'b0000)) begin errors++; $display("FAIL single_int_sel c=%0d got %b", c, obs[6:3]); end
    end
  endtask
  task automatic test_all_four;
    logic [3:0] es;
    drive(4'b0000, 1'b1, obs, exp_v);
    for (int c = 0; c < 10; c++) begin
      drive(c == 0 ? 4'b1111 : (c <= 8 ? 4'b1000 : 4'b0000), 1'b0, obs, exp_v);
      es = c == 1 ? 4'b0001 : c == 2 ? 4'b0010 : c == 4 ? 4'b0100 : c == 8 ? 4'b1000 : 4'b0000;
      checks++;
      if (obs !== exp_v) begin errors++; $display("FAIL all_four_model c=%0d got %b exp %b", c, obs, exp_v); end
      checks++;
      if (obs[10:7] !== (c == 0 ? 4'b1111 : c == 8 ? 4'b1000 : 4'b0000)) begin errors++; $display("FAIL all_four_issue c=%0d got %b", c, obs[10:7]); end
      checks++;
      if (obs[6:3] !== es) begin errors++; $display("FAIL all_four_sel c=%0d got %b exp %b", c, obs[6:3], es); end
      checks++;
      if (obs[1] !== ((c >= 1 && c <= 7) || c == 9)) begin errors++; $display("FAIL all_four_busy c=%0d got %b", c, obs[1]); end
    end
  endtask
  task automatic test_slot_conflict;
    drive(4'b0000, 1'b1, obs, exp_v);
    for (int c = 0; c < 7; c++) begin
      drive(c == 0 ? 4'b0100 : (c == 2 || c == 3) ? 4'b0010 : 4'b0000, 1'b0, obs, exp_v);
      checks++;
      if (obs !== exp_v) begin errors++; $display("FAIL conflict_model c=%0d got %b exp %b", c, obs, exp_v); end
      checks++;
      if (obs[8] !== (c == 3)) begin errors++; $display("FAIL conflict_ls_issue c=%0d got %b", c, obs[8]); end
      checks++;
      if (obs[6:3] !== (c == 4 ? 4'b0100 : c == 5 ? 4'b0010 : 4'b0000)) begin errors++; $display("FAIL conflict_sel c=%0d got %b", c, obs[6:3]); end
    end
  endtask
  task automatic test_starvation;
    drive(4'b0000, 1'b1, obs, exp_v);
    for (int c = 0; c < 12; c++) begin
      drive({2'b01, 1'b0, c >= 3 && c <= 9}, 1'b0, obs, exp_v);
      checks++;
      if (obs !== exp_v) begin errors++; $display("FAIL starve_model c=%0d got %b exp %b", c, obs, exp_v); end
      checks++;
      if (obs[9] !== (c <= 5 || c >= 10)) begin errors++; $display("FAIL starve_mult_issue c=%0d got %b", c, obs[9]); end
      checks++;
      if (obs[7] !== (c == 9)) begin errors++; $display("FAIL starve_int_issue c=%0d got %b", c, obs[7]); end
      checks++;
      if (obs[0] !== (c >= 6 && c <= 9)) begin errors++; $display("FAIL starve_active c=%0d got %b", c, obs[0]); end
      checks++;
      if (obs[6:3] !== (c >= 4 && c <= 9 ? 4'b0100 : c == 10 ? 4'b0001 : 4'b0000)) begin errors++; $display("FAIL starve_sel c=%0d got %b", c, obs[6:3]); end
    end
  endtask
  task automatic test_reset_mid;
    drive(4'b0000, 1'b1, obs, exp_v);
    for (int c = 0; c < 9; c++) begin
      drive((c == 0 || c == 4) ? 4'b1000 : 4'b0000, c == 3, obs, exp_v);
      checks++;
      if (obs !== exp_v) begin errors++; $display("FAIL rst_mid_model c=%0d got %b exp %b", c, obs, exp_v); end
      checks++;
      if (obs[1] !== (c >= 1 && c <= 3 || c >= 5)) begin errors++; $display("FAIL rst_mid_busy c=%0d got %b", c, obs[1]); end
      checks++;
      if (obs[10] !== (c == 0 || c == 4)) begin errors++; $display("FAIL rst_mid_div_issue c=%0d got %b", c, obs[10]); end
      checks++;
      if (obs[6:3] !== 4'b0000) begin errors++; $display("FAIL rst_mid_sel c=%0d got %b exp 0000", c, obs[6:3]); end
    end
  endtask
  task automatic test_back_to_back;
    drive(4'b0000, 1'b1, obs, exp_v);
    for (int c = 0; c < 15; c++) begin
      drive(c <= 9 ? 4'b0100 : 4'b0000, 1'b0, obs, exp_v);
      checks++;
      if (obs !== exp_v) begin errors++; $display("FAIL b2b_model c=%0d got %b exp %b", c, obs, exp_v); end
      checks++;
      if (obs[9] !== (c <= 9)) begin errors++; $display("FAIL b2b_issue c=%0d got %b", c, obs[9]); end
      checks++;
      if (obs[6:3] !== (c >= 4 && c <= 13 ? 4'b0100 : 4'b0000)) begin errors++; $display("FAIL b2b_sel c=%0d got %b", c, obs[6:3]); end
    end
  endtask
  task automatic test_random;
    drive(4'b0000, 1'b1, obs, exp_v);
    for (int c = 0; c < 600; c++) begin
      drive(4'($urandom), $urandom_range(0, 59) == 0, obs, exp_v);
      checks++;
      if (obs !== exp_v) begin errors++; $display("FAIL random_model c=%0d got %b exp %b", c, obs, exp_v); end
    end
  endtask
  initial begin
    for (int i = 0; i < N; i++) booked[i] = -1;
    {rst, int_ready, ls_ready, mult_ready, div_ready} = 5'b10000;
    @(negedge clk);
    test_reset;
    test_single_int;
    test_all_four;
    test_slot_conflict;
    test_starvation;
    test_reset_mid;
    test_back_to_back;
    test_random;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
